// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: stall-vector merge, exception redirect with multi-cycle flush, stall watchdog.
// Optional performance counters are built when CTRL_PERF_EN is defined.
module pipe_ctrl_unit #(
  parameter int unsigned NSTAGE    = 6,
  parameter int unsigned AW        = 32,
  parameter int unsigned FLUSH_LEN = 1,
  parameter logic [AW-1:0] INT_VEC = 'h20,
  parameter logic [AW-1:0] GEN_VEC = 'h40,
  parameter int unsigned IF_EXT    = 1,
  parameter int unsigned STALL_TMO = 1024,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic [31:0]       excepttype_i,
  input  logic [AW-1:0]     cp0_epc_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [AW-1:0]     new_pc_o,
  output logic              stall_tmo_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_count_o
);

  localparam int unsigned FW = $clog2(FLUSH_LEN + 1);
  localparam int unsigned SW = $clog2(STALL_TMO) + 1;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [AW-1:0]     pc_hold_q, pc_hold_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic              tmo_q, tmo_d;
  logic [AW-1:0]     exc_pc;
  logic [NSTAGE-1:0] req_stall;
  logic              unused_req0;

  // Bit 0 is the PC hold and is never requested directly.
  assign unused_req0 = stallreq_i[0];

  always_comb begin
    exc_pc = GEN_VEC;
    case (excepttype_i)
      32'h01:                         exc_pc = INT_VEC;
      32'h08, 32'h0a, 32'h0c, 32'h0d: exc_pc = GEN_VEC;
      32'h0e:                         exc_pc = cp0_epc_i;
      default:                        exc_pc = GEN_VEC;
    endcase
  end

  // Highest requesting stage holds itself and everything upstream of it.
  always_comb begin
    req_stall = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      if (stallreq_i[k]) req_stall = {NSTAGE{1'b1}} >> (NSTAGE - 1 - k);
    end
    if (IF_EXT != 0 && req_stall == NSTAGE'(3)) req_stall = req_stall | NSTAGE'(7);
  end

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    pc_hold_d = pc_hold_q;
    stall_o   = '0;
    flush_o   = 1'b0;
    new_pc_o  = '0;
    unique case (state_q)
      StRun: begin
        if (excepttype_i != '0) begin
          flush_o   = 1'b1;
          new_pc_o  = exc_pc;
          pc_hold_d = exc_pc;
          if (FLUSH_LEN > 1) begin
            state_d = StFlush;
            fcnt_d  = FW'(FLUSH_LEN - 1);
          end
        end else begin
          stall_o = req_stall;
        end
      end
      StFlush: begin
        flush_o  = 1'b1;
        new_pc_o = pc_hold_q;
        fcnt_d   = fcnt_q - FW'(1);
        if (fcnt_q == FW'(1)) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Watchdog counts consecutive stalled cycles; any unstalled or flush cycle restarts it.
  always_comb begin
    scnt_d = '0;
    if (stall_o != '0) begin
      scnt_d = (scnt_q == SW'(STALL_TMO)) ? scnt_q : scnt_q + SW'(1);
    end
    tmo_d = tmo_q | (scnt_d == SW'(STALL_TMO));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      fcnt_q    <= '0;
      pc_hold_q <= '0;
      scnt_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pc_hold_q <= pc_hold_d;
      scnt_q    <= scnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign stall_tmo_o = tmo_q;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_o != '0 && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      // Count exception entries only, not each flush cycle.
      if (state_q == StRun && excepttype_i != '0 && flush_count_q != '1) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomised bench for pipe_ctrl_unit: two configurations driven in parallel, each compared
// every cycle against a cycle-level behavioural model.
module tb_pipe_ctrl_unit;

  localparam int FL_A  = 3;
  localparam int FL_B  = 1;
  localparam int TMO_A = 8;
  localparam int TMO_B = 16;
  localparam int IFX_A = 1;
  localparam int IFX_B = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  req;
  logic [31:0] exc, epc;

  logic [5:0]  st  [2];
  logic        fl  [2];
  logic [31:0] np  [2];
  logic        tm  [2];
  logic [31:0] scy [2];
  logic [31:0] fcn [2];

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.NSTAGE(6), .AW(32), .FLUSH_LEN(FL_A), .INT_VEC(32'h20), .GEN_VEC(32'h40),
                   .IF_EXT(IFX_A), .STALL_TMO(TMO_A), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .stallreq_i(req), .excepttype_i(exc), .cp0_epc_i(epc),
    .stall_o(st[0]), .flush_o(fl[0]), .new_pc_o(np[0]), .stall_tmo_o(tm[0]),
    .stall_cycles_o(scy[0]), .flush_count_o(fcn[0])
  );

  pipe_ctrl_unit #(.NSTAGE(6), .AW(32), .FLUSH_LEN(FL_B), .INT_VEC(32'h20), .GEN_VEC(32'h40),
                   .IF_EXT(IFX_B), .STALL_TMO(TMO_B), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .stallreq_i(req), .excepttype_i(exc), .cp0_epc_i(epc),
    .stall_o(st[1]), .flush_o(fl[1]), .new_pc_o(np[1]), .stall_tmo_o(tm[1]),
    .stall_cycles_o(scy[1]), .flush_count_o(fcn[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Model state: remaining flush cycles after the current one, held redirect, stall run length.
  int          flush_left [2];
  logic [31:0] hold       [2];
  int          stall_run  [2];
  bit          tmo_flag   [2];
  int          n_stall    [2];
  int          n_exc      [2];
  int          exp_s      [2];
  logic [31:0] exp_p      [2];
  bit          model_ok = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      flush_left[i] = 0;
      hold[i]       = '0;
      stall_run[i]  = 0;
      tmo_flag[i]   = 1'b0;
      n_stall[i]    = 0;
      n_exc[i]      = 0;
    end
  endtask

  task automatic step(input logic r, input logic [5:0] q, input logic [31:0] e,
                      input logic [31:0] p);
    int    h, ifx, flen, tmo;
    bit    ef;
    string nm;
    rst = r; req = q; exc = e; epc = p;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ifx = (i == 0) ? IFX_A : IFX_B;
      nm  = (i == 0) ? "a" : "b";
      if (flush_left[i] > 0) begin
        ef = 1'b1; exp_p[i] = hold[i]; exp_s[i] = 0;
      end else if (e != 0) begin
        ef = 1'b1; exp_s[i] = 0;
        exp_p[i] = (e == 32'h01) ? 32'h20 : (e == 32'h0e) ? p : 32'h40;
      end else begin
        ef = 1'b0; exp_p[i] = '0;
        h = 0;
        for (int k = 1; k < 6; k++) if (q[k]) h = k;
        if (h == 0) exp_s[i] = 0;
        else if (h == 1 && ifx != 0) exp_s[i] = 7;
        else exp_s[i] = (1 << (h + 1)) - 1;
      end
      if (model_ok) begin
        check_eq({nm, " stall"}, 64'(st[i]), 64'(exp_s[i]));
        check_eq({nm, " flush"}, 64'(fl[i]), 64'(ef));
        check_eq({nm, " new_pc"}, 64'(np[i]), 64'(exp_p[i]));
        check_eq({nm, " stall_tmo"}, 64'(tm[i]), 64'(tmo_flag[i]));
`ifdef CTRL_PERF_EN
        check_eq({nm, " stall_cycles"}, 64'(scy[i]), 64'(n_stall[i]));
        check_eq({nm, " flush_count"}, 64'(fcn[i]), 64'(n_exc[i]));
`else
        check_eq({nm, " stall_cycles"}, 64'(scy[i]), 64'd0);
        check_eq({nm, " flush_count"}, 64'(fcn[i]), 64'd0);
`endif
      end
    end
    @(posedge clk);
    if (r) begin
      model_reset();
      model_ok = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        flen = (i == 0) ? FL_A : FL_B;
        tmo  = (i == 0) ? TMO_A : TMO_B;
        if (exp_s[i] != 0) begin
          stall_run[i]++;
          n_stall[i]++;
        end else begin
          stall_run[i] = 0;
        end
        if (stall_run[i] >= tmo) tmo_flag[i] = 1'b1;
        if (flush_left[i] > 0) begin
          flush_left[i]--;
        end else if (e != 0) begin
          hold[i]       = exp_p[i];
          flush_left[i] = flen - 1;
          n_exc[i]++;
        end
      end
    end
    #1;
  endtask

  logic [31:0] codes [7];
  logic [31:0] code;

  initial begin
    codes[0] = 32'h01; codes[1] = 32'h08; codes[2] = 32'h0a; codes[3] = 32'h0c;
    codes[4] = 32'h0d; codes[5] = 32'h0e; codes[6] = 32'h33;
    model_reset();
    rst = 1'b1; req = '0; exc = '0; epc = '0;
    #1;
    step(1'b1, 6'b0, 32'h0, 32'h0);
    step(1'b1, 6'b0, 32'h0, 32'h0);
    step(1'b0, 6'b0, 32'h0, 32'h0);
    // Stall merging, including the IF extension difference between the two instances.
    step(1'b0, 6'b001000, 32'h0, 32'h0);
    step(1'b0, 6'b011000, 32'h0, 32'h0);
    step(1'b0, 6'b000010, 32'h0, 32'h0);
    // eret beats a concurrent stall request.
    step(1'b0, 6'b010000, 32'h0e, 32'h1234);
    step(1'b0, 6'b000000, 32'h0, 32'h0);
    step(1'b0, 6'b000000, 32'h0, 32'h0);
    // Interrupt followed by a trap code that the 3-cycle flush must ignore.
    step(1'b0, 6'b000000, 32'h01, 32'h0);
    step(1'b0, 6'b000100, 32'h08, 32'h0);
    step(1'b0, 6'b000000, 32'h0, 32'h0);
    step(1'b0, 6'b000000, 32'h0, 32'h0);
    // Watchdog: long stall, then release.
    for (int c = 0; c < 10; c++) step(1'b0, 6'b001000, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) step(1'b0, 6'b000000, 32'h0, 32'h0);
    // Reset in the middle of a flush.
    step(1'b0, 6'b000000, 32'h05, 32'h0);
    step(1'b1, 6'b000000, 32'h0, 32'h0);
    step(1'b0, 6'b000000, 32'h0, 32'h0);
    step(1'b0, 6'b100000, 32'h0, 32'h0);
    // Random traffic: mostly stalls, occasional exceptions and resets.
    for (int c = 0; c < 500; c++) begin
      code = '0;
      if ($urandom_range(0, 7) == 0) code = codes[$urandom_range(0, 6)];
      step($urandom_range(0, 63) == 0, 6'($urandom), code, $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
